// File: rtl/pe_ctrl_sequencer_pkg.sv
// Shared PE control types: per-PE control word layout and the context sequencer state encoding.
package pe_ctrl_sequencer_pkg;

    localparam int CTRL_W = 8;

    // Field order matches the packed control word so a CTRL_W slice of ctrl_out casts directly.
    typedef struct packed {
        logic [2:0] sel_op_0;
        logic [2:0] sel_op_1;
        logic [1:0] alu_op;
    } pe_ctrl_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_RUN   = 3'd2,
        SEQ_DRAIN = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pe_ctrl_sequencer_ctx_mem.sv
// Context store: synchronous write, registered read with enable so the last context can be held.
module ctx_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The storage array is never reset; the read register is, because it drives ctrl_out directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// Loads a short program of per-PE control words, replays it for loop_count+1 passes,
// drains the PE pipeline and pulses done.
module pe_ctrl_sequencer #(
    parameter int NUM_PE    = 4,
    parameter int DEPTH     = 16,
    parameter int CTRL_W    = pe_ctrl_sequencer_pkg::CTRL_W,
    parameter int DRAIN_CYC = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int DW = NUM_PE * CTRL_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic [DW-1:0] load_data_i,
    input  logic          load_last_i,
    input  logic          start_i,
    input  logic [7:0]    loop_count_i,
    output logic          pe_en_o,
    output logic [DW-1:0] ctrl_out_o,
    output logic [AW-1:0] ctx_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    import pe_ctrl_sequencer_pkg::*;

    // state | meaning
    // IDLE  | program retained; accepts first load beat or start
    // LOAD  | collecting program words at wr_ptr
    // RUN   | replaying contexts, rd_ptr walks 0..prog_len-1 per pass
    // DRAIN | pe_en held for DRAIN_CYC cycles on the last context
    // DONE  | one-cycle completion, back to IDLE
    localparam logic [2:0] S_IDLE  = SEQ_IDLE;
    localparam logic [2:0] S_LOAD  = SEQ_LOAD;
    localparam logic [2:0] S_RUN   = SEQ_RUN;
    localparam logic [2:0] S_DRAIN = SEQ_DRAIN;
    localparam logic [2:0] S_DONE  = SEQ_DONE;

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    prog_len_q, prog_len_d;
    logic [7:0]     iter_q, iter_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic          pe_en_q, busy_q, done_q;
    logic [AW-1:0] ctx_idx_q;

    logic          load_beat;
    logic          rd_last;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_waddr;

    assign load_ready_o = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign load_beat    = load_valid_i && load_ready_o;
    assign rd_last      = ({1'b0, rd_ptr_q} == (prog_len_q - (AW+1)'(1)));
    assign mem_waddr    = (state_q == S_IDLE) ? '0 : wr_ptr_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        prog_len_d = prog_len_q;
        iter_d     = iter_q;
        drain_d    = drain_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A load beat outranks a simultaneous start: the program is being replaced.
                if (load_beat) begin
                    mem_we = 1'b1;
                    if (load_last_i) begin
                        prog_len_d = (AW+1)'(1);
                    end else begin
                        prog_len_d = '0;
                        wr_ptr_d   = AW'(1);
                        state_d    = S_LOAD;
                    end
                end else if (start_i && (prog_len_q != '0)) begin
                    iter_d   = loop_count_i;
                    rd_ptr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_LOAD: begin
                if (load_beat) begin
                    mem_we = 1'b1;
                    if (load_last_i || (wr_ptr_q == AW'(DEPTH - 1))) begin
                        prog_len_d = {1'b0, wr_ptr_q} + (AW+1)'(1);
                        state_d    = S_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            S_RUN: begin
                mem_re = 1'b1;
                if (rd_last) begin
                    rd_ptr_d = '0;
                    if (iter_q == 8'd0) begin
                        drain_d = DRAIN_LOAD;
                        state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        iter_d = iter_q - 8'd1;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            prog_len_q <= '0;
            iter_q     <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            prog_len_q <= prog_len_d;
            iter_q     <= iter_d;
            drain_q    <= drain_d;
        end
    end

    // Outputs lag the state by one edge, aligned with the registered memory read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ctx_idx_q <= '0;
        end else begin
            pe_en_q <= (state_q == S_RUN) || (state_q == S_DRAIN);
            busy_q  <= (state_q == S_RUN) || (state_q == S_DRAIN);
            done_q  <= (state_q == S_DONE);
            if (state_q == S_RUN) begin
                ctx_idx_q <= rd_ptr_q;
            end
        end
    end

    ctx_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_ctx_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (load_data_i),
        .re_i    (mem_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ctrl_out_o)
    );

    assign pe_en_o   = pe_en_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ctx_idx_o = ctx_idx_q;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Scoreboard bench for pe_ctrl_sequencer: a program-level model queues the expected context stream.
module tb_pe_ctrl_sequencer;

    localparam int NUM_PE = 4;
    localparam int DEPTH  = 16;
    localparam int CW     = 8;
    localparam int DRAIN  = 2;
    localparam int DW     = NUM_PE * CW;
    localparam int AW     = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          load_valid_i = 1'b0;
    logic          load_ready_o;
    logic [DW-1:0] load_data_i = '0;
    logic          load_last_i = 1'b0;
    logic          start_i = 1'b0;
    logic [7:0]    loop_count_i = '0;
    logic          pe_en_o;
    logic [DW-1:0] ctrl_out_o;
    logic [AW-1:0] ctx_idx_o;
    logic          busy_o;
    logic          done_o;

    pe_ctrl_sequencer #(
        .NUM_PE    (NUM_PE),
        .DEPTH     (DEPTH),
        .CTRL_W    (CW),
        .DRAIN_CYC (DRAIN)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .start_i      (start_i),
        .loop_count_i (loop_count_i),
        .pe_en_o      (pe_en_o),
        .ctrl_out_o   (ctrl_out_o),
        .ctx_idx_o    (ctx_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit            is_done;
        logic [DW-1:0] ctrl;
        int            idx;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_seen = 0;
    bit prev_pe_en = 1'b0;

    // Reference program: what the sequencer should hold after the beats seen so far.
    logic [DW-1:0] mmem [DEPTH];
    int  mlen = 0;
    int  mwptr = 0;
    bit  mloading = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_beat(input logic [DW-1:0] w, input bit last);
        if (!mloading) begin
            mmem[0] = w;
            if (last) begin
                mlen = 1;
            end else begin
                mlen = 0;
                mloading = 1'b1;
                mwptr = 1;
            end
        end else begin
            mmem[mwptr] = w;
            if (last || mwptr == DEPTH - 1) begin
                mlen = mwptr + 1;
                mloading = 1'b0;
            end else begin
                mwptr++;
            end
        end
    endfunction

    function automatic void push_run(input int lc);
        exp_t e;
        for (int it = 0; it <= lc; it++) begin
            for (int i = 0; i < mlen; i++) begin
                e.is_done = 1'b0; e.ctrl = mmem[i]; e.idx = i;
                exp_q.push_back(e);
            end
        end
        for (int d = 0; d < DRAIN; d++) begin
            e.is_done = 1'b0; e.ctrl = mmem[mlen-1]; e.idx = mlen - 1;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1; e.ctrl = '0; e.idx = 0;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_ni) begin
            if (busy_o) busy_cnt++;
            if (pe_en_o || done_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: pe_en=%0b done=%0b ctrl=%0h idx=%0d with nothing expected",
                             pe_en_o, done_o, ctrl_out_o, ctx_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    if (done_o) begin
                        chk("done_slot{kind,pe_en,prev_pe_en}", 32'({e.is_done, pe_en_o, prev_pe_en}), 32'(3'b101));
                    end else begin
                        chk("ctx_kind", 32'(e.is_done), 32'd0);
                        chk("ctx_ctrl", ctrl_out_o, e.ctrl);
                        chk("ctx_idx", 32'(ctx_idx_o), 32'(e.idx));
                        chk("busy_with_en", 32'(busy_o), 32'd1);
                    end
                end
                if (done_o) done_seen++;
            end
            prev_pe_en = pe_en_o;
        end
    end

    // Entry and exit at 1 time unit after a rising edge.
    task automatic load_prog(input int n, input bit use_last, input bit gappy);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            bit last;
            if (gappy) begin
                load_valid_i = 1'b0;
                load_last_i = 1'b0;
                @(posedge clk_i); #1;
            end
            w = DW'($urandom);
            last = use_last && (i == n - 1);
            load_valid_i = 1'b1;
            load_data_i = w;
            load_last_i = last;
            chk("load_ready", 32'(load_ready_o), 32'd1);
            @(posedge clk_i); #1;
            model_beat(w, last);
        end
        load_valid_i = 1'b0;
        load_last_i = 1'b0;
    endtask

    task automatic run_prog(input int lc);
        int exp_cycles, budget, b0, d0;
        exp_cycles = mlen * (lc + 1) + DRAIN;
        push_run(lc);
        b0 = busy_cnt;
        d0 = done_seen;
        start_i = 1'b1;
        loop_count_i = 8'(lc);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("start_latency_edge_n", 32'(pe_en_o), 32'd0);
        @(posedge clk_i); #1;
        chk("start_latency_edge_n1", 32'(pe_en_o), 32'd1);
        budget = exp_cycles + 20;
        while (done_seen == d0 && budget > 0) begin
            @(posedge clk_i); #1;
            budget--;
        end
        if (done_seen == d0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: no done within %0d cycles", exp_cycles + 20);
        end
        @(posedge clk_i); #1;
        chk("busy_cycles", 32'(busy_cnt - b0), 32'(exp_cycles));
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic start_ignored(input string name);
        int b0, d0;
        b0 = busy_cnt;
        d0 = done_seen;
        start_i = 1'b1;
        loop_count_i = 8'($urandom_range(0, 3));
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (6) begin
            @(posedge clk_i); #1;
        end
        chk({name, "_busy"}, 32'(busy_cnt - b0), 32'd0);
        chk({name, "_done"}, 32'(done_seen - d0), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_load_ready", 32'(load_ready_o), 32'd1);
        chk("rst_pe_en", 32'(pe_en_o), 32'd0);
        chk("rst_ctrl_out", ctrl_out_o, 32'd0);
        chk("rst_ctx_idx", 32'(ctx_idx_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        #10 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        start_ignored("start_no_program");

        // Three words, single pass, then three passes of the same program.
        load_prog(3, 1'b1, 1'b0);
        run_prog(0);
        run_prog(2);

        // Sixteen beats without last fill and close the program; the next last-beat replaces it.
        load_prog(16, 1'b0, 1'b0);
        chk("trunc_prog_len", 32'(mlen), 32'd16);
        run_prog(1);
        load_prog(1, 1'b1, 1'b0);
        run_prog(0);

        // Seventeenth beat without last reopens loading, so start must be ignored.
        load_prog(17, 1'b0, 1'b0);
        start_ignored("start_during_load");
        load_prog(1, 1'b1, 1'b0);
        run_prog(0);

        // load_valid toggling every other cycle.
        load_prog(4, 1'b1, 1'b1);
        run_prog(1);

        // Reset in the third RUN cycle.
        load_prog(5, 1'b1, 1'b0);
        push_run(3);
        start_i = 1'b1;
        loop_count_i = 8'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrun_rst_pe_en", 32'(pe_en_o), 32'd0);
        chk("midrun_rst_busy", 32'(busy_o), 32'd0);
        chk("midrun_rst_ctrl_out", ctrl_out_o, 32'd0);
        chk("midrun_rst_ctx_idx", 32'(ctx_idx_o), 32'd0);
        chk("midrun_rst_load_ready", 32'(load_ready_o), 32'd1);
        exp_q.delete();
        mlen = 0;
        mloading = 1'b0;
        #4 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        start_ignored("start_after_reset");
        load_prog(2, 1'b1, 1'b0);
        run_prog(0);

        // Randomized programs, occasionally re-run without reloading.
        for (int t = 0; t < 10; t++) begin
            int n;
            bit ul;
            n = $urandom_range(1, 16);
            ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            load_prog(n, ul, 1'($urandom_range(0, 1)));
            run_prog($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) run_prog($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
